sequential_chunk_adder: RTL and testbench

- Parametrised multi-cycle adder; successor to the combinational half adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK_W bits per clock, and ripples the carry between chunks through a register.
- Trades latency for a short critical path; used where wide adds must meet timing without a wide carry chain.
- Valid/ready handshake on both input and output sides.

---
 rtl/sequential_chunk_adder.sv | 125 ++++++++++++
 tb/tb_sequential_chunk_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sequential_chunk_adder.sv
// Multi-cycle adder: CHUNK_W bits per clock, carry rippled through a register, valid/ready on both sides.
// Optional subtract mode enabled by defining SEQ_CHUNK_ADDER_SUB_EN (adds Mode_In port).
module sequential_chunk_adder #(
    parameter int WIDTH   = 32,
    parameter int CHUNK_W = 8
) (
    input  logic             Clk_In,
    input  logic             Reset_N_In,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             Mode_In,
`endif
    input  logic             In_Valid_In,
    output logic             In_Ready_Out,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
    input  logic             Carry_In,
    output logic             Out_Valid_Out,
    input  logic             Out_Ready_In,
    output logic [WIDTH-1:0] Sum_Out,
    output logic             Carry_Out,
    output logic             Overflow_Out
);
    localparam int NUM_CHUNKS = WIDTH / CHUNK_W;
    localparam int KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NUM_CHUNKS - 1);

    if (WIDTH % CHUNK_W != 0) begin : g_bad_chunk
        $error("sequential_chunk_adder: WIDTH must be a multiple of CHUNK_W");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, work_q, sum_q;
    logic [KW-1:0]    k_q;
    logic             carry_q, cout_q, ovf_q;
    logic             in_ready_q, out_valid_q;

    int               base;
    logic [CHUNK_W-1:0] chunk_a, chunk_b;
    logic [CHUNK_W:0]   chunk_res;
    logic [WIDTH-1:0]   work_d;
    logic               ovf_d;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;

    always_comb begin
        base      = int'(k_q) * CHUNK_W;
        chunk_a   = a_q[base +: CHUNK_W];
        chunk_b   = b_q[base +: CHUNK_W];
        chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK_W{1'b0}}, carry_q};
        work_d    = work_q;
        work_d[base +: CHUNK_W] = chunk_res[CHUNK_W-1:0];
        // Carry into the MSB recovered from its sum bit; only meaningful on the final chunk.
        ovf_d     = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ work_d[WIDTH-1]) ^ chunk_res[CHUNK_W];
    end

    always_comb begin
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        b_eff   = Mode_In ? ~Data_B_In : Data_B_In;
        cin_eff = Mode_In ? 1'b1 : Carry_In;
`else
        b_eff   = Data_B_In;
        cin_eff = Carry_In;
`endif
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (In_Valid_In) begin
                        a_q        <= Data_A_In;
                        b_q        <= b_eff;
                        carry_q    <= cin_eff;
                        work_q     <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    work_q  <= work_d;
                    carry_q <= chunk_res[CHUNK_W];
                    k_q     <= k_q + KW'(1);
                    if (k_q == LAST_K) begin
                        k_q         <= '0;
                        sum_q       <= work_d;
                        cout_q      <= chunk_res[CHUNK_W];
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (Out_Ready_In) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign In_Ready_Out  = in_ready_q;
    assign Out_Valid_Out = out_valid_q;
    assign Sum_Out       = sum_q;
    assign Carry_Out     = cout_q;
    assign Overflow_Out  = ovf_q;

endmodule

// File: tb/tb_sequential_chunk_adder.sv
// Directed-vector bench for sequential_chunk_adder (WIDTH=32, CHUNK_W=8).
module tb_sequential_chunk_adder;
    localparam int WIDTH = 32;

    logic             Clk_In = 1'b0;
    logic             Reset_N_In;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic             Mode_In;
`endif
    logic             In_Valid_In, In_Ready_Out;
    logic [WIDTH-1:0] Data_A_In, Data_B_In, Sum_Out;
    logic             Carry_In, Out_Valid_Out, Out_Ready_In, Carry_Out, Overflow_Out;

    always #5 Clk_In = ~Clk_In;

    sequential_chunk_adder #(.WIDTH(32), .CHUNK_W(8)) dut (
        .Clk_In(Clk_In),
        .Reset_N_In(Reset_N_In),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .Mode_In(Mode_In),
`endif
        .In_Valid_In(In_Valid_In),
        .In_Ready_Out(In_Ready_Out),
        .Data_A_In(Data_A_In),
        .Data_B_In(Data_B_In),
        .Carry_In(Carry_In),
        .Out_Valid_Out(Out_Valid_Out),
        .Out_Ready_In(Out_Ready_In),
        .Sum_Out(Sum_Out),
        .Carry_Out(Carry_Out),
        .Overflow_Out(Overflow_Out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t        vecs[6];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] prev_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge Clk_In);
        chk({tag, "_in_ready"}, 32'(In_Ready_Out), 32'd1);
        Data_A_In   = a;
        Data_B_In   = b;
        Carry_In    = cin;
        In_Valid_In = 1'b1;
        @(posedge Clk_In);
        #1;
        In_Valid_In = 1'b0;
        Data_A_In   = 32'hDEADBEEF;
        Data_B_In   = 32'h5A5A5A5A;
        Carry_In    = ~cin;
        lat = 0;
        while (Out_Valid_Out !== 1'b1 && lat < 20) begin
            @(posedge Clk_In);
            #1;
            lat++;
            if (lat == 1) chk({tag, "_sum_hold"}, Sum_Out, prev_sum);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, Sum_Out, es);
        chk({tag, "_cout"}, 32'(Carry_Out), 32'(ec));
        chk({tag, "_ovf"}, 32'(Overflow_Out), 32'(eo));
        prev_sum = es;
        @(negedge Clk_In);
        Out_Ready_In = 1'b1;
        @(posedge Clk_In);
        #1;
        Out_Ready_In = 1'b0;
        chk({tag, "_valid_drop"}, 32'(Out_Valid_Out), 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1, 1'b0};

        Reset_N_In   = 1'b1;
        In_Valid_In  = 1'b0;
        Out_Ready_In = 1'b0;
        Data_A_In    = '0;
        Data_B_In    = '0;
        Carry_In     = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        Mode_In      = 1'b0;
`endif
        prev_sum     = '0;
        #2 Reset_N_In = 1'b0;
        repeat (2) @(posedge Clk_In);
        #1;
        chk("rst_in_ready", 32'(In_Ready_Out), 32'd1);
        chk("rst_out_valid", 32'(Out_Valid_Out), 32'd0);
        chk("rst_sum", Sum_Out, 32'd0);
        chk("rst_cout", 32'(Carry_Out), 32'd0);
        chk("rst_ovf", 32'(Overflow_Out), 32'd0);
        @(negedge Clk_In);
        Reset_N_In = 1'b1;

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        // Backpressure with an ignored request while DONE
        @(negedge Clk_In);
        Data_A_In = 32'd1; Data_B_In = 32'd2; Carry_In = 1'b0; In_Valid_In = 1'b1;
        @(posedge Clk_In);
        #1;
        In_Valid_In = 1'b0;
        repeat (4) @(posedge Clk_In);
        #1;
        chk("bp_valid_rise", 32'(Out_Valid_Out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk_In);
            In_Valid_In = (i == 2);
            Data_A_In   = 32'd100;
            Data_B_In   = 32'd200;
            @(posedge Clk_In);
            #1;
            chk($sformatf("bp_valid_%0d", i), 32'(Out_Valid_Out), 32'd1);
            chk($sformatf("bp_sum_%0d", i), Sum_Out, 32'd3);
            chk($sformatf("bp_in_ready_%0d", i), 32'(In_Ready_Out), 32'd0);
        end
        @(negedge Clk_In);
        In_Valid_In  = 1'b0;
        Out_Ready_In = 1'b1;
        @(posedge Clk_In);
        #1;
        Out_Ready_In = 1'b0;
        chk("bp_release_valid", 32'(Out_Valid_Out), 32'd0);
        chk("bp_release_ready", 32'(In_Ready_Out), 32'd1);
        chk("bp_release_sum", Sum_Out, 32'd3);
        repeat (3) @(posedge Clk_In);
        #1;
        chk("bp_not_queued", 32'(In_Ready_Out), 32'd1);
        prev_sum = 32'd3;

        // Reset during the second BUSY cycle
        @(negedge Clk_In);
        Data_A_In = 32'h10; Data_B_In = 32'h20; In_Valid_In = 1'b1;
        @(posedge Clk_In);
        #1;
        In_Valid_In = 1'b0;
        @(posedge Clk_In);
        #2;
        Reset_N_In = 1'b0;
        #1;
        chk("midrst_sum", Sum_Out, 32'd0);
        chk("midrst_valid", 32'(Out_Valid_Out), 32'd0);
        chk("midrst_ready", 32'(In_Ready_Out), 32'd1);
        @(negedge Clk_In);
        Reset_N_In = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge Clk_In);
            #1;
            if (Out_Valid_Out === 1'b1) seen++;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        prev_sum = 32'd0;
        do_op("after_rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        Mode_In = 1'b1;
        do_op("sub_5_7", 32'd5, 32'd7, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sub_7_5", 32'd7, 32'd5, 1'b0, 32'd2, 1'b1, 1'b0);
        Mode_In = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
